// File: rtl/opnd_fwd_stage.sv
// Operand selection and RAW forwarding between decode and execute.
// A one-entry valid/ready register holds the selected operands. Load-use
// hazards stall the stage, and a saturating counter tracks stall cycles.
module opnd_fwd_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_FWD = 3,
   parameter int CNT_W   = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic                      o_valid,
   input  logic                      i_ready,
   input  logic                      i_flush,
   input  logic [1:0]                i_opa_sel,
   input  logic [1:0]                i_opb_sel,
   input  logic                      i_rs2_used,
   input  logic [ADDR_W-1:0]         i_rs1_addr,
   input  logic [ADDR_W-1:0]         i_rs2_addr,
   input  logic [DATA_W-1:0]         i_rs1_data,
   input  logic [DATA_W-1:0]         i_rs2_data,
   input  logic [DATA_W-1:0]         i_pc,
   input  logic [DATA_W-1:0]         i_imm,
   input  logic [NUM_FWD-1:0]        i_fwd_valid,
   input  logic [NUM_FWD-1:0]        i_fwd_pending,
   input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
   output logic [DATA_W-1:0]         o_operand_a,
   output logic [DATA_W-1:0]         o_operand_b,
   output logic [DATA_W-1:0]         o_store_data,
   output logic [CNT_W-1:0]          o_stall_cnt
);

   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic              rs1_haz;
   logic              rs2_haz;
   logic              hazard;
   logic              capture;
   logic              stall_inc;
   logic [DATA_W-1:0] opa_val;
   logic [DATA_W-1:0] opb_val;

   // Forward lookup. The scan runs from the oldest source to the youngest,
   // so the lowest-index match is written last and wins. Register x0 is
   // never forwarded.
   always_comb begin
      rs1_val = i_rs1_data;
      rs2_val = i_rs2_data;
      rs1_haz = 1'b0;
      rs2_haz = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (i_fwd_valid[i] && (i_rs1_addr != '0) &&
             (i_fwd_addr[i*ADDR_W +: ADDR_W] == i_rs1_addr)) begin
            rs1_val = i_fwd_data[i*DATA_W +: DATA_W];
            rs1_haz = i_fwd_pending[i];
         end
         if (i_fwd_valid[i] && (i_rs2_addr != '0) &&
             (i_fwd_addr[i*ADDR_W +: ADDR_W] == i_rs2_addr)) begin
            rs2_val = i_fwd_data[i*DATA_W +: DATA_W];
            rs2_haz = i_fwd_pending[i];
         end
      end
   end

   // Operand muxes, hazard detection and handshake.
   always_comb begin
      case (i_opa_sel)
         2'd0:    opa_val = rs1_val;
         2'd1:    opa_val = i_pc;
         default: opa_val = '0;
      endcase
      case (i_opb_sel)
         2'd0:    opb_val = rs2_val;
         2'd1:    opb_val = i_imm;
         2'd2:    opb_val = DATA_W'(4);
         default: opb_val = '0;
      endcase
      hazard    = (rs1_haz && (i_opa_sel == 2'd0)) || (rs2_haz && i_rs2_used);
      o_ready   = (!o_valid || i_ready) && !hazard;
      capture   = i_valid && o_ready && !i_flush;
      stall_inc = i_valid && hazard && !i_flush;
   end

   // Output register. A flush kills both the held and the incoming entry.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid      <= 1'b0;
         o_operand_a  <= '0;
         o_operand_b  <= '0;
         o_store_data <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (capture) begin
         o_valid      <= 1'b1;
         o_operand_a  <= opa_val;
         o_operand_b  <= opb_val;
         o_store_data <= rs2_val;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

   // Saturating stall counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
      end else if (stall_inc && (o_stall_cnt != '1)) begin
         o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_opnd_fwd_stage.sv
// Scoreboard bench for opnd_fwd_stage. The driver pushes the expected
// operands for each instruction it issues. The monitor pops and compares
// them on every output handshake.
module tb_opnd_fwd_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic        o_valid;
   logic        i_ready;
   logic        i_flush;
   logic [1:0]  i_opa_sel;
   logic [1:0]  i_opb_sel;
   logic        i_rs2_used;
   logic [4:0]  i_rs1_addr;
   logic [4:0]  i_rs2_addr;
   logic [31:0] i_rs1_data;
   logic [31:0] i_rs2_data;
   logic [31:0] i_pc;
   logic [31:0] i_imm;
   logic [2:0]  i_fwd_valid;
   logic [2:0]  i_fwd_pending;
   logic [14:0] i_fwd_addr;
   logic [95:0] i_fwd_data;
   logic [31:0] o_operand_a;
   logic [31:0] o_operand_b;
   logic [31:0] o_store_data;
   logic [15:0] o_stall_cnt;

   logic        s_ready;
   logic        s_valid;
   logic [31:0] s_operand_a;
   logic [31:0] s_operand_b;
   logic [31:0] s_store_data;
   logic [1:0]  s_stall_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
   } exp_t;
   exp_t sb[$];

   always #5 i_clk = ~i_clk;

   opnd_fwd_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .o_valid(o_valid), .i_ready(i_ready), .i_flush(i_flush),
      .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel), .i_rs2_used(i_rs2_used),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .i_pc(i_pc), .i_imm(i_imm), .i_fwd_valid(i_fwd_valid),
      .i_fwd_pending(i_fwd_pending), .i_fwd_addr(i_fwd_addr),
      .i_fwd_data(i_fwd_data), .o_operand_a(o_operand_a),
      .o_operand_b(o_operand_b), .o_store_data(o_store_data),
      .o_stall_cnt(o_stall_cnt)
   );

   opnd_fwd_stage #(.CNT_W(2)) dut_sat (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(s_ready),
      .o_valid(s_valid), .i_ready(i_ready), .i_flush(i_flush),
      .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel), .i_rs2_used(i_rs2_used),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .i_pc(i_pc), .i_imm(i_imm), .i_fwd_valid(i_fwd_valid),
      .i_fwd_pending(i_fwd_pending), .i_fwd_addr(i_fwd_addr),
      .i_fwd_data(i_fwd_data), .o_operand_a(s_operand_a),
      .o_operand_b(s_operand_b), .o_store_data(s_store_data),
      .o_stall_cnt(s_stall_cnt)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Monitor: compare on each handshake; a flushed entry is discarded.
   always @(negedge i_clk) begin
      if (!i_reset && o_valid) begin
         if (i_flush) begin
            if (sb.size() > 0) void'(sb.pop_front());
         end else if (i_ready) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("opa", o_operand_a, e.a);
               chk("opb", o_operand_b, e.b);
               chk("store", o_store_data, e.sd);
            end
         end
      end
   end

   task automatic set_instr(input logic [1:0] opa, input logic [1:0] opb,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] rs1d, input logic [31:0] rs2d,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic used);
      i_opa_sel = opa; i_opb_sel = opb; i_rs1_addr = rs1; i_rs2_addr = rs2;
      i_rs1_data = rs1d; i_rs2_data = rs2d; i_pc = pc; i_imm = imm;
      i_rs2_used = used;
   endtask

   task automatic set_fwd(input int idx, input logic v, input logic p,
                          input logic [4:0] addr, input logic [31:0] data);
      i_fwd_valid[idx] = v;
      i_fwd_pending[idx] = p;
      i_fwd_addr[idx*5 +: 5] = addr;
      i_fwd_data[idx*32 +: 32] = data;
   endtask

   task automatic clear_fwd();
      i_fwd_valid = '0; i_fwd_pending = '0; i_fwd_addr = '0; i_fwd_data = '0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Issue the current inputs with a bounded wait for capture.
   task automatic issue(input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] esd);
      bit ok = 0;
      int n = 0;
      sb.push_back('{a: ea, b: eb, sd: esd});
      i_valid = 1'b1;
      while (!ok && n < 20) begin
         @(negedge i_clk);
         if (o_ready && !i_flush) ok = 1;
         step();
         n++;
      end
      i_valid = 1'b0;
      if (!ok) chk("issue_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1; i_valid = 0; i_ready = 1; i_flush = 0;
      set_instr(2'd0, 2'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      clear_fwd();
      repeat (2) step();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_a", o_operand_a, 32'd0);
      chk("rst_b", o_operand_b, 32'd0);
      chk("rst_sd", o_store_data, 32'd0);
      chk("rst_cnt", 32'(o_stall_cnt), 32'd0);
      i_reset = 0;

      // PC + immediate, one-cycle latency
      set_instr(2'd1, 2'd1, 5'd0, 5'd3, 32'd0, 32'h77, 32'h100, 32'hFFFF_FFF0, 1'b0);
      issue(32'h100, 32'hFFFF_FFF0, 32'h77);
      chk("latency_valid", 32'(o_valid), 32'd1);

      // forwarding priority and x0
      set_instr(2'd0, 2'd2, 5'd5, 5'd0, 32'h5555, 32'd0, 32'd0, 32'd0, 1'b0);
      set_fwd(0, 1, 0, 5'd5, 32'hAA);
      set_fwd(2, 1, 0, 5'd5, 32'hBB);
      issue(32'hAA, 32'd4, 32'd0);
      set_fwd(0, 0, 0, 5'd0, 32'd0);
      set_instr(2'd0, 2'd3, 5'd5, 5'd0, 32'h5555, 32'd0, 32'd0, 32'd0, 1'b0);
      issue(32'hBB, 32'd0, 32'd0);
      clear_fwd();
      set_fwd(0, 1, 0, 5'd0, 32'h55);
      set_instr(2'd0, 2'd0, 5'd0, 5'd9, 32'd0, 32'h1111, 32'd0, 32'd0, 1'b1);
      issue(32'd0, 32'h1111, 32'h1111);

      // load-use stall for three cycles
      clear_fwd();
      set_fwd(1, 1, 1, 5'd7, 32'hDEAD);
      set_instr(2'd1, 2'd1, 5'd0, 5'd7, 32'd0, 32'h7777, 32'h200, 32'h20, 1'b1);
      sb.push_back('{a: 32'h200, b: 32'h20, sd: 32'h1234});
      i_valid = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("lu_ready", 32'(o_ready), 32'd0);
         step();
      end
      chk("lu_cnt", 32'(o_stall_cnt), 32'd3);
      set_fwd(1, 1, 0, 5'd7, 32'h1234);
      @(negedge i_clk);
      chk("lu_release", 32'(o_ready), 32'd1);
      step();
      i_valid = 0;

      // younger non-pending match masks older pending one
      set_fwd(0, 1, 0, 5'd7, 32'h9);
      set_fwd(1, 1, 1, 5'd7, 32'hDEAD);
      set_instr(2'd1, 2'd1, 5'd0, 5'd7, 32'd0, 32'h7777, 32'h300, 32'h30, 1'b1);
      issue(32'h300, 32'h30, 32'h9);
      chk("mask_cnt", 32'(o_stall_cnt), 32'd3);
      step();

      // backpressure
      clear_fwd();
      i_ready = 0;
      set_instr(2'd1, 2'd2, 5'd0, 5'd4, 32'd0, 32'h44, 32'h400, 32'd0, 1'b0);
      issue(32'h400, 32'd4, 32'h44);
      i_valid = 1;
      for (int k = 0; k < 4; k++) begin
         i_pc = 32'h500 + 32'(k);
         i_rs2_data = 32'h90 + 32'(k);
         @(negedge i_clk);
         chk("bp_ready", 32'(o_ready), 32'd0);
         chk("bp_valid", 32'(o_valid), 32'd1);
         chk("bp_a", o_operand_a, 32'h400);
         chk("bp_b", o_operand_b, 32'd4);
         chk("bp_sd", o_store_data, 32'h44);
         step();
      end
      set_instr(2'd1, 2'd1, 5'd0, 5'd4, 32'd0, 32'h45, 32'h600, 32'h66, 1'b0);
      sb.push_back('{a: 32'h600, b: 32'h66, sd: 32'h45});
      i_ready = 1;
      @(negedge i_clk);
      chk("bp_release", 32'(o_ready), 32'd1);
      step();
      i_valid = 0;
      step();

      // flush kills held and incoming entries
      i_ready = 0;
      set_instr(2'd1, 2'd1, 5'd0, 5'd4, 32'd0, 32'h77, 32'h700, 32'h8, 1'b0);
      issue(32'h700, 32'h8, 32'h77);
      set_instr(2'd1, 2'd1, 5'd0, 5'd4, 32'd0, 32'h88, 32'h800, 32'h9, 1'b0);
      i_valid = 1; i_flush = 1;
      step();
      i_valid = 0; i_flush = 0;
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_nocap", o_operand_a, 32'h700);
      i_ready = 1;

      // hazard on an unused operand does not stall
      set_fwd(1, 1, 1, 5'd7, 32'd0);
      set_instr(2'd1, 2'd1, 5'd7, 5'd7, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      @(negedge i_clk);
      chk("unused_ready", 32'(o_ready), 32'd1);
      i_opa_sel = 2'd0;
      #1;
      chk("used_ready", 32'(o_ready), 32'd0);
      step();

      // counter saturation, and no count while flushing
      chk("sb_drained", 32'(sb.size()), 32'd0);
      i_reset = 1;
      step();
      i_reset = 0;
      chk("sat_rst", 32'(s_stall_cnt), 32'd0);
      i_valid = 1;
      repeat (5) step();
      chk("cnt5", 32'(o_stall_cnt), 32'd5);
      chk("sat_cnt", 32'(s_stall_cnt), 32'd3);
      i_flush = 1;
      step();
      chk("flush_nocnt", 32'(o_stall_cnt), 32'd5);
      i_flush = 0; i_valid = 0;
      clear_fwd();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/opnd_fwd_stage.md
Name: opnd_fwd_stage

Overview:
- Parametrised operand-selection and forwarding stage for the pipelined RV32I core, sitting between decode and execute.
- Selects operand A (rs1/PC/zero) and operand B (rs2/immediate/constant 4).
- Resolves RAW hazards by forwarding from up to NUM_FWD later stages, and stalls on load-use.
- Registers the result in a one-entry valid/ready pipeline register with flush, and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, operand and data width
ADDR_W, 5, register address width
NUM_FWD, 3, number of forwarding sources; index 0 = youngest stage, highest priority
CNT_W, 16, width of saturating stall counter

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept instruction this cycle
o_valid  out  1  registered operands valid
i_ready  in  1  downstream (execute) accepts
i_flush  in  1  kill held and incoming instruction (branch mispredict/trap)
i_opa_sel  in  2  0=rs1, 1=PC, 2=zero, 3=zero
i_opb_sel  in  2  0=rs2, 1=imm, 2=constant 4, 3=zero
i_rs2_used  in  1  rs2 value consumed (store data or opb_sel=0)
i_rs1_addr  in  ADDR_W  rs1 index
i_rs2_addr  in  ADDR_W  rs2 index
i_rs1_data  in  DATA_W  regfile rs1 value
i_rs2_data  in  DATA_W  regfile rs2 value
i_pc  in  DATA_W  instruction PC
i_imm  in  DATA_W  sign-extended immediate
i_fwd_valid  in  NUM_FWD  source i writes a register
i_fwd_pending  in  NUM_FWD  source i result not yet available (load in flight)
i_fwd_addr  in  NUM_FWD*ADDR_W  destination index, source i at bits [i*ADDR_W +: ADDR_W]
i_fwd_data  in  NUM_FWD*DATA_W  result, source i at bits [i*DATA_W +: DATA_W]
o_operand_a  out  DATA_W  registered operand A
o_operand_b  out  DATA_W  registered operand B
o_store_data  out  DATA_W  registered forwarded rs2 value
o_stall_cnt  out  CNT_W  hazard stall cycles, saturating

Behaviour:
- Reset (sync, i_reset=1 at posedge): o_valid=0; o_operand_a, o_operand_b, o_store_data = 0; o_stall_cnt=0. Reset overrides flush and capture.
- Forward lookup for rs1 and rs2 independently (combinational):
  - Select the lowest index i with i_fwd_valid[i]=1 and i_fwd_addr[i]==rs_addr.
  - rs_addr==0 never matches; the value is the regfile value, which is 0.
  - No match -> regfile data.
  - Match with pending[i]=0 -> i_fwd_data[i].
  - Match with pending[i]=1 -> hazard for that register.
  - A lower-index non-pending match masks a higher-index pending match.
- hazard = (rs1 hazard and i_opa_sel==0) or (rs2 hazard and i_rs2_used).
- o_ready = (!o_valid or i_ready) and !hazard. Combinational; no dependence on i_valid.
- Capture when i_valid & o_ready & !i_flush:
  - Output registers load the selected A, selected B and forwarded rs2.
  - o_valid=1 next cycle.
  - Latency: 1 cycle.
- o_valid & !i_ready: all outputs hold stable. Incoming data is not captured and o_ready=0.
- o_valid & i_ready & no new capture: o_valid=0 next cycle. Data registers may hold their old values.
- i_flush=1: o_valid=0 next cycle regardless of i_valid, i_ready or hazard. No capture occurs. o_stall_cnt does not increment that cycle.
- Stall counter:
  - Increments by 1 on each cycle with i_valid & hazard & !i_flush & !i_reset.
  - Saturates at 2^CNT_W-1; no wrap.
- Operand A with sel=1 uses i_pc unmodified; sel 2/3 give 0. Operand B with sel=2 gives DATA_W'(4).
- A hazard on an unused operand (e.g. rs1 pending while opa_sel=1) does not stall.

Test Plan:
- Reset, then i_valid with opa_sel=1, pc=0x100, opb_sel=1, imm=0xFFFFFFF0, i_ready=1 -> next cycle o_valid=1, A=0x100, B=0xFFFFFFF0.
- rs1=5; fwd0 and fwd2 both valid for x5 with data 0xAA and 0xBB, none pending -> A=0xAA (index-0 priority). Same with only fwd2 -> A=0xBB. rs1=0 with fwd0 addr=0 data=0x55 -> A=regfile value 0.
- Load-use: fwd1 valid+pending for x7, rs2=7, i_rs2_used=1, held 3 cycles then pending drops with data 0x1234:
  - o_ready=0 for 3 cycles; o_stall_cnt=3.
  - Next cycle captures; o_store_data=0x1234.
- fwd0 non-pending x7=0x9 and fwd1 pending x7 -> no stall, o_store_data=0x9.
- Backpressure: o_valid=1, i_ready=0 for 4 cycles while inputs change -> outputs constant and o_ready=0. Release i_ready -> next instruction captured one cycle later.
- i_flush while o_valid=1 and i_valid=1 -> o_valid=0 next cycle, nothing captured. With CNT_W=2 and 5 hazard cycles -> o_stall_cnt=3 (saturated).
